// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared definitions for the host-side manycore AXI-Lite link:
// register offsets, AXI response codes and the register decoder.
package bsg_manycore_link_to_axil_pkg;

  localparam logic [7:0] tx_data_offset_gp    = 8'h00;
  localparam logic [7:0] tx_credits_offset_gp = 8'h04;
  localparam logic [7:0] rx_data_offset_gp    = 8'h08;
  localparam logic [7:0] rx_status_offset_gp  = 8'h0C;

  localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axil_resp_slverr_gp = 2'b10;
  localparam logic [1:0] axil_resp_decerr_gp = 2'b11;

  typedef enum logic [2:0] {
    e_reg_tx_data,
    e_reg_tx_credits,
    e_reg_rx_data,
    e_reg_rx_status,
    e_reg_none
  } link_reg_e;

  // Only the word index addr[4:2] selects a register; other bits alias.
  function automatic link_reg_e link_reg_decode(input logic [2:0] word_idx);
    link_reg_e r;
    r = e_reg_none;
    if (word_idx == tx_data_offset_gp[4:2])    r = e_reg_tx_data;
    if (word_idx == tx_credits_offset_gp[4:2]) r = e_reg_tx_credits;
    if (word_idx == rx_data_offset_gp[4:2])    r = e_reg_rx_data;
    if (word_idx == rx_status_offset_gp[4:2])  r = e_reg_rx_status;
    return r;
  endfunction

endpackage

// File: rtl/bsg_manycore_link_axil_slave_if.sv
// AXI4-Lite bus bundle between the host master and the manycore link slave.
interface bsg_manycore_link_axil_slave_if #(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32
);
  logic [axil_addr_width_p-1:0]   awaddr;
  logic                           awvalid;
  logic                           awready;
  logic [axil_data_width_p-1:0]   wdata;
  logic [axil_data_width_p/8-1:0] wstrb;
  logic                           wvalid;
  logic                           wready;
  logic [1:0]                     bresp;
  logic                           bvalid;
  logic                           bready;
  logic [axil_addr_width_p-1:0]   araddr;
  logic                           arvalid;
  logic                           arready;
  logic [axil_data_width_p-1:0]   rdata;
  logic [1:0]                     rresp;
  logic                           rvalid;
  logic                           rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/bsg_manycore_link_axil_slave.sv
// AXI4-Lite slave front end of the host manycore link: pushes TX words,
// pops RX words and reports TX credits / RX status through a 4-register map.
module bsg_manycore_link_axil_slave
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter int axil_data_width_p   = 32,
  parameter int axil_addr_width_p   = 32,
  parameter int req_credits_width_p = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  bsg_manycore_link_axil_slave_if.slave  s_axil,
  output logic [axil_data_width_p-1:0]   axil_req_o,
  output logic                           axil_req_v_o,
  input  logic                           axil_req_ready_i,
  input  logic [axil_data_width_p-1:0]   axil_rsp_i,
  input  logic                           axil_rsp_v_i,
  output logic                           axil_rsp_ready_o,
  input  logic [req_credits_width_p-1:0] req_credits_i
);

  typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_e;

  w_state_e                     w_state_q, w_state_d;
  logic                         aw_latched_q, aw_latched_d;
  logic                         w_latched_q, w_latched_d;
  logic [2:0]                   waddr_q, waddr_d;
  logic [axil_data_width_p-1:0] wdata_q, wdata_d;
  logic [1:0]                   bresp_q, bresp_d;

  r_state_e                     r_state_q, r_state_d;
  logic [2:0]                   raddr_q, raddr_d;
  logic [axil_data_width_p-1:0] rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;

  logic awready, wready, arready, req_v, rsp_ready;
  logic unused_bits;

  assign unused_bits = ^{s_axil.awaddr[axil_addr_width_p-1:5], s_axil.awaddr[1:0],
                         s_axil.araddr[axil_addr_width_p-1:5], s_axil.araddr[1:0],
                         s_axil.wstrb};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_state_q    <= W_IDLE;
      aw_latched_q <= 1'b0;
      w_latched_q  <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      bresp_q      <= '0;
      r_state_q    <= R_IDLE;
      raddr_q      <= '0;
      rdata_q      <= '0;
      rresp_q      <= '0;
    end else begin
      w_state_q    <= w_state_d;
      aw_latched_q <= aw_latched_d;
      w_latched_q  <= w_latched_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      bresp_q      <= bresp_d;
      r_state_q    <= r_state_d;
      raddr_q      <= raddr_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
    end
  end

  // Write side: AW and W are accepted independently, then one push cycle.
  always_comb begin
    w_state_d    = w_state_q;
    aw_latched_d = aw_latched_q;
    w_latched_d  = w_latched_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    bresp_d      = bresp_q;
    awready      = 1'b0;
    wready       = 1'b0;
    req_v        = 1'b0;
    axil_req_o   = '0;
    case (w_state_q)
      W_IDLE: begin
        awready = ~aw_latched_q;
        wready  = ~w_latched_q;
        if (awready && s_axil.awvalid) begin
          aw_latched_d = 1'b1;
          waddr_d      = s_axil.awaddr[4:2];
        end
        if (wready && s_axil.wvalid) begin
          w_latched_d = 1'b1;
          wdata_d     = s_axil.wdata;
        end
        if (aw_latched_d && w_latched_d) begin
          w_state_d    = W_PUSH;
          aw_latched_d = 1'b0;
          w_latched_d  = 1'b0;
        end
      end
      W_PUSH: begin
        w_state_d = W_RESP;
        if (link_reg_decode(waddr_q) == e_reg_tx_data) begin
          req_v      = axil_req_ready_i;
          axil_req_o = wdata_q;
          bresp_d    = axil_req_ready_i ? axil_resp_okay_gp : axil_resp_slverr_gp;
        end else begin
          bresp_d = axil_resp_decerr_gp;
        end
      end
      W_RESP: begin
        if (s_axil.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read side: every register is sampled in the fetch cycle, not at AR.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready   = 1'b0;
    rsp_ready = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (s_axil.arvalid) begin
          raddr_d   = s_axil.araddr[4:2];
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        r_state_d = R_RESP;
        rdata_d   = '0;
        rresp_d   = axil_resp_okay_gp;
        case (link_reg_decode(raddr_q))
          e_reg_tx_credits: rdata_d = axil_data_width_p'(req_credits_i);
          e_reg_rx_data: begin
            rsp_ready = axil_rsp_v_i;
            if (axil_rsp_v_i) rdata_d = axil_rsp_i;
            else              rresp_d = axil_resp_slverr_gp;
          end
          e_reg_rx_status:  rdata_d[0] = axil_rsp_v_i;
          default:          rresp_d = axil_resp_decerr_gp;
        endcase
      end
      R_RESP: begin
        if (s_axil.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Handshake-side outputs are forced low while reset is held.
  assign s_axil.awready = awready & ~reset_i;
  assign s_axil.wready  = wready & ~reset_i;
  assign s_axil.arready = arready & ~reset_i;
  assign axil_req_v_o   = req_v & ~reset_i;
  assign axil_rsp_ready_o = rsp_ready & ~reset_i;

  assign s_axil.bvalid = (w_state_q == W_RESP);
  assign s_axil.bresp  = bresp_q;
  assign s_axil.rvalid = (r_state_q == R_RESP);
  assign s_axil.rdata  = rdata_q;
  assign s_axil.rresp  = rresp_q;

endmodule
